// File: rtl/ascon_ad_ctrl.sv
// rtl/ascon_ad_ctrl.sv - Ascon associated-data absorb sequencer (block handshake, rounds, domain separation)
module ascon_ad_ctrl #(
    parameter int ROUND_START = 6,
    parameter int ROUND_LAST  = 11,
    parameter int CNT_W       = 8
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             init_end_i,
    input  logic             ad_empty_i,
    input  logic             ad_valid_i,
    input  logic             ad_last_i,
    output logic             ad_ready_o,
    output logic [3:0]       round_o,
    output logic             en_reg_state_o,
    output logic             en_xor_data_o,
    output logic             en_xor_lsb_o,
    output logic             done_o,
    output logic [CNT_W-1:0] ad_count_o
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_AD,
        ABSORB,
        ROUNDS,
        DOMSEP,
        DONE
    } state_t;

    state_t state;
    logic   last_q;

    // Outputs are registered together with the state: each branch loads the
    // output values belonging to the state being entered, so round_o doubles
    // as the round counter.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state          <= IDLE;
            last_q         <= 1'b0;
            ad_count_o     <= '0;
            round_o        <= 4'd0;
            ad_ready_o     <= 1'b0;
            en_reg_state_o <= 1'b0;
            en_xor_data_o  <= 1'b0;
            en_xor_lsb_o   <= 1'b0;
            done_o         <= 1'b0;
        end else begin
            round_o        <= 4'd0;
            ad_ready_o     <= 1'b0;
            en_reg_state_o <= 1'b0;
            en_xor_data_o  <= 1'b0;
            en_xor_lsb_o   <= 1'b0;
            done_o         <= 1'b0;
            case (state)
                IDLE: begin
                    if (init_end_i) begin
                        ad_count_o <= '0;
                        if (ad_empty_i) begin
                            state          <= DOMSEP;
                            en_xor_lsb_o   <= 1'b1;
                            en_reg_state_o <= 1'b1;
                        end else begin
                            state      <= WAIT_AD;
                            ad_ready_o <= 1'b1;
                        end
                    end
                end
                WAIT_AD: begin
                    // ad_ready_o is 1 throughout this state, so valid alone completes the transfer
                    if (ad_valid_i) begin
                        state          <= ABSORB;
                        last_q         <= ad_last_i;
                        round_o        <= 4'(ROUND_START);
                        en_xor_data_o  <= 1'b1;
                        en_reg_state_o <= 1'b1;
                    end else begin
                        ad_ready_o <= 1'b1;
                    end
                end
                ABSORB: begin
                    state          <= ROUNDS;
                    round_o        <= 4'(ROUND_START + 1);
                    en_reg_state_o <= 1'b1;
                end
                ROUNDS: begin
                    if (round_o == 4'(ROUND_LAST)) begin
                        if (ad_count_o != {CNT_W{1'b1}}) begin
                            ad_count_o <= ad_count_o + CNT_W'(1);
                        end
                        if (last_q) begin
                            state          <= DOMSEP;
                            en_xor_lsb_o   <= 1'b1;
                            en_reg_state_o <= 1'b1;
                        end else begin
                            state      <= WAIT_AD;
                            ad_ready_o <= 1'b1;
                        end
                    end else begin
                        round_o        <= round_o + 4'd1;
                        en_reg_state_o <= 1'b1;
                    end
                end
                DOMSEP: begin
                    state  <= DONE;
                    done_o <= 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ascon_ad_ctrl.sv
// tb/tb_ascon_ad_ctrl.sv - randomized message-level checks of ascon_ad_ctrl at CNT_W=8 and CNT_W=2
module tb_ascon_ad_ctrl;

    logic       clock_i = 1'b0;
    logic       reset_i, init_end_i, ad_empty_i, ad_valid_i, ad_last_i;

    logic       a_ready, a_reg, a_xd, a_xl, a_done;
    logic [3:0] a_round;
    logic [7:0] a_count;
    logic       b_ready, b_reg, b_xd, b_xl, b_done;
    logic [3:0] b_round;
    logic [1:0] b_count;

    int n_checks = 0;
    int n_err    = 0;
    int exp_cnt8 = 0;
    int exp_cnt2 = 0;

    always #5 clock_i = ~clock_i;

    ascon_ad_ctrl dut_a (
        .clock_i(clock_i), .reset_i(reset_i), .init_end_i(init_end_i),
        .ad_empty_i(ad_empty_i), .ad_valid_i(ad_valid_i), .ad_last_i(ad_last_i),
        .ad_ready_o(a_ready), .round_o(a_round), .en_reg_state_o(a_reg),
        .en_xor_data_o(a_xd), .en_xor_lsb_o(a_xl), .done_o(a_done),
        .ad_count_o(a_count)
    );

    ascon_ad_ctrl #(.CNT_W(2)) dut_b (
        .clock_i(clock_i), .reset_i(reset_i), .init_end_i(init_end_i),
        .ad_empty_i(ad_empty_i), .ad_valid_i(ad_valid_i), .ad_last_i(ad_last_i),
        .ad_ready_o(b_ready), .round_o(b_round), .en_reg_state_o(b_reg),
        .en_xor_data_o(b_xd), .en_xor_lsb_o(b_xl), .done_o(b_done),
        .ad_count_o(b_count)
    );

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    // Check the outputs of the current cycle, then drive this cycle's inputs and advance.
    task automatic cyc(input string ph, input logic e_rdy, input logic e_xd, input logic e_xl,
                       input logic e_rg, input logic e_dn, input int e_rnd,
                       input logic d_rst, input logic d_init, input logic d_empty,
                       input logic d_valid, input logic d_last);
        chk({ph, ".a_ready"}, a_ready, e_rdy);
        chk({ph, ".a_xor_data"}, a_xd, e_xd);
        chk({ph, ".a_xor_lsb"}, a_xl, e_xl);
        chk({ph, ".a_en_reg"}, a_reg, e_rg);
        chk({ph, ".a_done"}, a_done, e_dn);
        chk({ph, ".a_round"}, a_round, 32'(e_rnd));
        chk({ph, ".a_count"}, a_count, 32'(exp_cnt8));
        chk({ph, ".b_ready"}, b_ready, e_rdy);
        chk({ph, ".b_xor_data"}, b_xd, e_xd);
        chk({ph, ".b_xor_lsb"}, b_xl, e_xl);
        chk({ph, ".b_en_reg"}, b_reg, e_rg);
        chk({ph, ".b_done"}, b_done, e_dn);
        chk({ph, ".b_round"}, b_round, 32'(e_rnd));
        chk({ph, ".b_count"}, b_count, 32'(exp_cnt2));
        reset_i    = d_rst;
        init_end_i = d_init;
        ad_empty_i = d_empty;
        ad_valid_i = d_valid;
        ad_last_i  = d_last;
        @(posedge clock_i);
        #1;
    endtask

    // One message: n blocks (0 = empty AD), gap idle cycles before each block
    // (-1 = random 0..4), abort_blk = block index whose round 9 is hit by reset.
    task automatic run_msg(input int n, input int gap, input int abort_blk);
        int g;
        cyc("idle", 0, 0, 0, 0, 0, 0, 1'b0, 1'b1, n == 0, rb(), rb());
        exp_cnt8 = 0;
        exp_cnt2 = 0;
        for (int b = 0; b < n; b++) begin
            g = (gap < 0) ? int'($urandom_range(0, 4)) : gap;
            for (int k = 0; k < g; k++)
                cyc("wait", 1, 0, 0, 0, 0, 0, 1'b0, rb(), rb(), 1'b0, rb());
            cyc("handshake", 1, 0, 0, 0, 0, 0, 1'b0, rb(), rb(), 1'b1, b == n - 1);
            cyc("absorb", 0, 1, 0, 1, 0, 6, 1'b0, rb(), rb(), rb(), rb());
            for (int r = 7; r <= 11; r++) begin
                if (b == abort_blk && r == 9) begin
                    cyc("rounds_rst", 0, 0, 0, 1, 0, r, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
                    exp_cnt8 = 0;
                    exp_cnt2 = 0;
                    cyc("post_rst", 0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0, rb(), rb());
                    return;
                end
                cyc("rounds", 0, 0, 0, 1, 0, r, 1'b0, rb(), rb(), rb(), rb());
            end
            if (exp_cnt8 < 255) exp_cnt8++;
            if (exp_cnt2 < 3) exp_cnt2++;
        end
        cyc("domsep", 0, 0, 1, 1, 0, 0, 1'b0, rb(), rb(), rb(), rb());
        cyc("done", 0, 0, 0, 0, 1, 0, 1'b0, rb(), rb(), rb(), rb());
    endtask

    initial begin
        reset_i    = 1'b1;
        init_end_i = 1'b0;
        ad_empty_i = 1'b0;
        ad_valid_i = 1'b0;
        ad_last_i  = 1'b0;
        @(posedge clock_i);
        #1;
        cyc("in_reset", 0, 0, 0, 0, 0, 0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        cyc("after_reset", 0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc("idle_valid", 0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        run_msg(0, 0, -1);
        run_msg(1, 0, -1);
        run_msg(3, 4, -1);
        run_msg(3, 2, 1);
        run_msg(1, 1, -1);
        run_msg(5, -1, -1);
        for (int m = 0; m < 25; m++)
            run_msg(int'($urandom_range(0, 6)), -1, -1);
        cyc("final_idle", 0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/ascon_ad_ctrl.md
ASCON_AD_CTRL -- requirements
Module: ascon_ad_ctrl

Interface
REQ-001 Parameter ROUND_START, default 6, round index driven on the first associated-data (AD) round (Ascon-128 p^6 = rounds 6..11).
REQ-002 Parameter ROUND_LAST, default 11, round index of the final permutation round.
REQ-003 Parameter CNT_W, default 8, width of the absorbed-block counter.
REQ-004 clock_i  in  1  single system clock, all state updates on its rising edge.
REQ-005 reset_i  in  1  synchronous, active-high reset.
REQ-006 init_end_i  in  1  one-cycle pulse from the initialisation stage: state register holds the post-init state.
REQ-007 ad_empty_i  in  1  sampled with init_end_i, 1 = no AD for this message.
REQ-008 ad_valid_i  in  1  upstream presents a 64-bit AD block on the shared data bus.
REQ-009 ad_last_i  in  1  qualifies ad_valid_i: this block is the final (padded) AD block.
REQ-010 ad_ready_o  out  1  block accepts an AD block this cycle.
REQ-011 round_o  out  4  round index for the permutation datapath.
REQ-012 en_reg_state_o  out  1  state register load enable.
REQ-013 en_xor_data_o  out  1  XOR the AD block into x0 before this round.
REQ-014 en_xor_lsb_o  out  1  domain separation: XOR 1 into LSB of x4.
REQ-015 done_o  out  1  one-cycle pulse: AD phase complete, state ready for plaintext stage.
REQ-016 ad_count_o  out  CNT_W  number of AD blocks absorbed in the current message.

Function
REQ-017 FSM states SHALL be IDLE, WAIT_AD, ABSORB, ROUNDS, DOMSEP, DONE.
REQ-018 IDLE: all outputs 0 except round_o = 0; on init_end_i=1 go to DOMSEP if ad_empty_i=1, else WAIT_AD; ad_count_o cleared to 0 on that edge.
REQ-019 WAIT_AD: ad_ready_o = 1 (combinational from state only, never from ad_valid_i); transfer occurs when ad_valid_i & ad_ready_o; on transfer latch ad_last_i and go to ABSORB.
REQ-020 ABSORB (one cycle): round_o = ROUND_START, en_xor_data_o = 1, en_reg_state_o = 1; next ROUNDS with round counter = ROUND_START+1.
REQ-021 ROUNDS: en_reg_state_o = 1, round_o = counter, counter +1 per cycle; when round_o = ROUND_LAST, increment ad_count_o and go to DOMSEP if latched last = 1, else WAIT_AD.
REQ-022 Per block: handshake cycle to last round = ROUND_LAST-ROUND_START+1 = 6 cycles of en_reg_state_o.
REQ-023 DOMSEP (one cycle): en_xor_lsb_o = 1, en_reg_state_o = 1, round_o = 0; next DONE.
REQ-024 DONE (one cycle): done_o = 1; next IDLE.
REQ-025 ad_count_o SHALL saturate at 2^CNT_W-1, never wrap.
REQ-026 init_end_i in any state other than IDLE SHALL be ignored.
REQ-027 ad_valid_i outside WAIT_AD SHALL be ignored (no latch, no counter change).
REQ-028 en_xor_data_o and en_xor_lsb_o SHALL never be 1 in the same cycle; en_xor_* = 1 implies en_reg_state_o = 1.
REQ-029 All outputs SHALL be registered-state decodes (Moore); no output depends combinationally on any input.

Reset
REQ-030 reset_i = 1 at a rising edge SHALL force IDLE, round counter 0, latched last 0, ad_count_o 0, in any state including mid-round.
REQ-031 During and the cycle after reset, ad_ready_o, en_* and done_o SHALL be 0, round_o = 0.
REQ-032 reset_i SHALL take priority over init_end_i and ad_valid_i in the same cycle.

Verification
REQ-033 Empty AD: init_end_i=1, ad_empty_i=1 -> next cycle DOMSEP (en_xor_lsb_o=1), then done_o=1, ad_count_o=0, ad_ready_o never asserted.
REQ-034 One block: init, then ad_valid_i=1, ad_last_i=1 -> en_xor_data_o=1 with round_o=6 once, round_o 7..11 on next 5 cycles, DOMSEP, done_o; ad_count_o=1.
REQ-035 Three blocks with ad_valid_i held 0 for 4 cycles between blocks -> ad_ready_o=1 throughout each wait, three ABSORB cycles, ad_count_o=3, exactly one en_xor_lsb_o and one done_o.
REQ-036 Reset at round_o=9 of block 2 -> following cycle IDLE, all outputs 0, ad_count_o=0; subsequent init_end_i starts clean sequence.
REQ-037 Spurious init_end_i during ROUNDS and ad_valid_i during ROUNDS -> no state or counter change; sequence timing identical to REQ-034.
REQ-038 CNT_W=2, five blocks -> ad_count_o reads 1,2,3,3,3; done_o still asserted once after fifth block.
